// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT/BTB of 2-bit saturating counters with tagged targets.
// Fetch looks up next-PC prediction; decode resolves, flags mispredictions and trains.
module branch_predictor_bht #(
  parameter int         INDEX_BITS = 6,
  parameter int         TAG_BITS   = 8,
  parameter logic [1:0] CTR_INIT   = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] f_pc,
  output logic        f_taken,
  output logic [31:0] f_target,
  input  logic        r_valid,
  input  logic [31:0] r_pc,
  input  logic [31:0] r_instr,
  input  logic        r_eq,
  input  logic [31:0] r_vs,
  input  logic        r_pred_taken,
  input  logic [31:0] r_pred_target,
  output logic        miss,
  output logic [31:0] rpc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_misses
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic                valid_q  [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic [INDEX_BITS-1:0] f_idx, r_idx;
  logic [TAG_BITS-1:0]   f_tag, r_tag;
  logic                  f_hit, r_hit;

  assign f_idx = f_pc[INDEX_BITS+1:2];
  assign f_tag = f_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign r_idx = r_pc[INDEX_BITS+1:2];
  assign r_tag = r_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  // Lookup sees registered contents only, so a same-cycle update is not bypassed.
  assign f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_taken  = f_hit && ctr_q[f_idx][1];
  assign f_target = f_taken ? target_q[f_idx] : f_pc + 32'd4;

  logic [5:0]  op, funct;
  logic        is_beq, is_bne, is_j, is_jal, is_jr, is_ctrl;
  logic [31:0] pc4, br_target, jmp_target, target;
  logic        actual_taken;
  logic [31:0] actual_next;

  assign op      = r_instr[31:26];
  assign funct   = r_instr[5:0];
  assign is_beq  = (op == 6'b000100);
  assign is_bne  = (op == 6'b000101);
  assign is_j    = (op == 6'b000010);
  assign is_jal  = (op == 6'b000011);
  assign is_jr   = (op == 6'b000000) && (funct == 6'b001000);
  assign is_ctrl = is_beq || is_bne || is_j || is_jal || is_jr;

  assign pc4        = r_pc + 32'd4;
  assign br_target  = pc4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign jmp_target = {pc4[31:28], r_instr[25:0], 2'b00};

  always_comb begin
    target       = br_target;
    actual_taken = 1'b0;
    if (is_jr) begin
      target       = r_vs;
      actual_taken = 1'b1;
    end else if (is_j || is_jal) begin
      target       = jmp_target;
      actual_taken = 1'b1;
    end else if (is_beq) begin
      actual_taken = r_eq;
    end else if (is_bne) begin
      actual_taken = !r_eq;
    end
  end

  assign actual_next = actual_taken ? target : pc4;
  assign miss = r_valid && ((r_pred_taken != actual_taken) ||
                            (actual_taken && (r_pred_target != target)));
  assign rpc  = miss ? actual_next : 32'd0;

  logic train, alloc, evict, wr_target;
  assign r_hit     = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign train     = r_valid && is_ctrl && r_hit;
  assign alloc     = r_valid && is_ctrl && !r_hit && actual_taken;
  assign evict     = r_valid && !is_ctrl && r_hit;
  assign wr_target = alloc || (train && actual_taken);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
      stat_branches <= 32'd0;
      stat_misses   <= 32'd0;
    end else begin
      if (alloc) begin
        valid_q[r_idx] <= 1'b1;
        ctr_q[r_idx]   <= CTR_INIT;
      end else if (train) begin
        if (actual_taken && ctr_q[r_idx] != 2'b11)
          ctr_q[r_idx] <= ctr_q[r_idx] + 2'b01;
        else if (!actual_taken && ctr_q[r_idx] != 2'b00)
          ctr_q[r_idx] <= ctr_q[r_idx] - 2'b01;
      end else if (evict) begin
        valid_q[r_idx] <= 1'b0;
      end
      if (r_valid && is_ctrl) stat_branches <= stat_branches + 32'd1;
      if (miss)               stat_misses   <= stat_misses + 32'd1;
    end
  end

  // Tag/target need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (!reset && wr_target) begin
      tag_q[r_idx]    <= r_tag;
      target_q[r_idx] <= target;
    end
  end
endmodule
